// File: rtl/fpu_div_arbiter.sv
// Round-robin sequencer that shares one multi-cycle divider among NUM_REQ requesters.
// One division in flight: IDLE -> CLEAR -> START -> WAIT -> RESP, with a WAIT timeout.
module fpu_div_arbiter #(
    parameter int unsigned FP_W           = 16,
    parameter int unsigned CC_W           = 4,
    parameter int unsigned FLAG_W         = 5,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             reqValid,
    output logic [NUM_REQ-1:0]             reqReady,
    input  logic [NUM_REQ-1:0][FP_W-1:0]   reqIn1,
    input  logic [NUM_REQ-1:0][FP_W-1:0]   reqIn2,
    output logic [NUM_REQ-1:0]             rspValid,
    input  logic [NUM_REQ-1:0]             rspReady,
    output logic [FP_W-1:0]                rspOut,
    output logic [CC_W-1:0]                rspCondCodes,
    output logic [FLAG_W-1:0]              rspFlags,
    output logic                           rspTimeout,
    output logic                           divReset,
    output logic                           divStart,
    output logic [FP_W-1:0]                divIn1,
    output logic [FP_W-1:0]                divIn2,
    input  logic [FP_W-1:0]                divOut,
    input  logic                           divDone,
    input  logic [CC_W-1:0]                divCondCodes,
    input  logic [FLAG_W-1:0]              divFlags
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   grant_idx_q, grant_idx_d;
    logic [FP_W-1:0]   op_a_q, op_a_d;
    logic [FP_W-1:0]   op_b_q, op_b_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [FP_W-1:0]   rsp_out_q, rsp_out_d;
    logic [CC_W-1:0]   rsp_cc_q, rsp_cc_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic              req_found;
    logic [IdxW-1:0]   req_sel;
    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   next_ptr;
    logic              rsp_active;

    // First valid requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        cand      = '0;
        for (int unsigned o = 0; o < NUM_REQ; o++) begin
            cand = IdxW'((32'(rr_ptr_q) + o) % NUM_REQ);
            if (!req_found && reqValid[cand]) begin
                req_found = 1'b1;
                req_sel   = cand;
            end
        end
        next_ptr = IdxW'((32'(req_sel) + 1) % NUM_REQ);
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        timer_d       = timer_q;
        rsp_out_d     = rsp_out_q;
        rsp_cc_d      = rsp_cc_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_timeout_d = rsp_timeout_q;
        reqReady      = '0;
        rspValid      = '0;
        divStart      = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_found) begin
                    reqReady[req_sel] = 1'b1;
                    op_a_d            = reqIn1[req_sel];
                    op_b_d            = reqIn2[req_sel];
                    grant_idx_d       = req_sel;
                    rr_ptr_d          = next_ptr;
                    state_d           = StClear;
                end
            end
            StClear: state_d = StStart;
            StStart: begin
                divStart = 1'b1;
                timer_d  = '0;
                state_d  = StWait;
            end
            StWait: begin
                // A done seen on the last timer cycle still returns the real result.
                if (divDone) begin
                    rsp_out_d     = divOut;
                    rsp_cc_d      = divCondCodes;
                    rsp_flags_d   = divFlags;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (timer_q == TmrLast) begin
                    rsp_out_d     = '0;
                    rsp_cc_d      = '0;
                    rsp_flags_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StResp: begin
                rspValid[grant_idx_q] = 1'b1;
                if (rspReady[grant_idx_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (reset) begin
            reqReady = '0;
            rspValid = '0;
            divStart = 1'b0;
        end
    end

    assign rsp_active   = (state_q == StResp) && !reset;
    assign rspOut       = rsp_active ? rsp_out_q : '0;
    assign rspCondCodes = rsp_active ? rsp_cc_q : '0;
    assign rspFlags     = rsp_active ? rsp_flags_q : '0;
    assign rspTimeout   = rsp_active ? rsp_timeout_q : 1'b0;
    assign divReset     = reset | (state_q == StClear);
    assign divIn1       = op_a_q;
    assign divIn2       = op_b_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            timer_q       <= '0;
            rsp_out_q     <= '0;
            rsp_cc_q      <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_idx_q   <= grant_idx_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            timer_q       <= timer_d;
            rsp_out_q     <= rsp_out_d;
            rsp_cc_q      <= rsp_cc_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Directed bench for fpu_div_arbiter with a behavioural divider stub of programmable latency.
module tb_fpu_div_arbiter;

    logic              clk;
    logic              rst;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][15:0]  req_in1;
    logic [3:0][15:0]  req_in2;
    logic [3:0]        rsp_valid;
    logic [3:0]        rsp_ready;
    logic [15:0]       rsp_out;
    logic [3:0]        rsp_cc;
    logic [4:0]        rsp_flags;
    logic              rsp_timeout;
    logic              div_reset;
    logic              div_start;
    logic [15:0]       div_in1;
    logic [15:0]       div_in2;
    logic [15:0]       div_out;
    logic              div_done;
    logic [3:0]        div_cc;
    logic [4:0]        div_flags;

    int checks;
    int failures;

    // Divider stub: done rises stub_lat+1 cycles after start unless hung.
    logic        stub_busy;
    int          stub_cnt;
    logic        stub_done_q;
    int          stub_lat;
    bit          stub_hang;
    logic [15:0] stub_result;
    logic [3:0]  stub_cc;
    logic [4:0]  stub_fl;

    fpu_div_arbiter #(
        .FP_W          (16),
        .CC_W          (4),
        .FLAG_W        (5),
        .NUM_REQ       (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .reqValid    (req_valid),
        .reqReady    (req_ready),
        .reqIn1      (req_in1),
        .reqIn2      (req_in2),
        .rspValid    (rsp_valid),
        .rspReady    (rsp_ready),
        .rspOut      (rsp_out),
        .rspCondCodes(rsp_cc),
        .rspFlags    (rsp_flags),
        .rspTimeout  (rsp_timeout),
        .divReset    (div_reset),
        .divStart    (div_start),
        .divIn1      (div_in1),
        .divIn2      (div_in2),
        .divOut      (div_out),
        .divDone     (div_done),
        .divCondCodes(div_cc),
        .divFlags    (div_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_reset) begin
            stub_busy   <= 1'b0;
            stub_cnt    <= 0;
            stub_done_q <= 1'b0;
        end else if (div_start) begin
            stub_busy   <= 1'b1;
            stub_cnt    <= 0;
            stub_done_q <= 1'b0;
        end else if (stub_busy && !stub_hang) begin
            if (stub_cnt == stub_lat) begin
                stub_done_q <= 1'b1;
                stub_busy   <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    assign div_done  = stub_done_q;
    assign div_out   = stub_result;
    assign div_cc    = stub_cc;
    assign div_flags = stub_fl;

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid === 4'b0000 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_ready(output int cyc);
        #1;
        cyc = 0;
        while (req_ready === 4'b0000 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_rsp(input logic [3:0] oh);
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        repeat (2) @(negedge clk);
        checks++; if (div_reset !== 1'b1) begin failures++; $display("FAIL rst_div_reset got=%b exp=1", div_reset); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL rst_div_start got=%b exp=0", div_start); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (div_reset !== 1'b0) begin failures++; $display("FAIL idle_div_reset got=%b exp=0", div_reset); end
        checks++; if (div_in1 !== 16'h0000) begin failures++; $display("FAIL rst_div_in1 got=%h exp=0000", div_in1); end
        checks++; if (rsp_out !== 16'h0000) begin failures++; $display("FAIL rst_rsp_out got=%h exp=0000", rsp_out); end
    endtask

    task automatic test_basic();
        int cyc;
        stub_lat = 0; stub_hang = 1'b0;
        stub_result = 16'h3800; stub_cc = 4'h1; stub_fl = 5'h00;
        req_in1[0] = 16'h3C00; req_in2[0] = 16'h4000; req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL basic_ready got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++; if (div_reset !== 1'b1) begin failures++; $display("FAIL basic_clear got=%b exp=1", div_reset); end
        checks++; if (div_in1 !== 16'h3C00) begin failures++; $display("FAIL basic_in1 got=%h exp=3c00", div_in1); end
        checks++; if (div_in2 !== 16'h4000) begin failures++; $display("FAIL basic_in2 got=%h exp=4000", div_in2); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL basic_ready_busy got=%b exp=0000", req_ready); end
        @(negedge clk);
        checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL basic_start got=%b exp=1", div_start); end
        checks++; if (div_reset !== 1'b0) begin failures++; $display("FAIL basic_start_rst got=%b exp=0", div_reset); end
        wait_rsp(cyc);
        checks++; if (cyc !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", cyc); end
        checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL basic_rsp_valid got=%b exp=0001", rsp_valid); end
        checks++; if (rsp_out !== 16'h3800) begin failures++; $display("FAIL basic_rsp_out got=%h exp=3800", rsp_out); end
        checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", rsp_timeout); end
        checks++; if (rsp_cc !== 4'h1) begin failures++; $display("FAIL basic_cc got=%h exp=1", rsp_cc); end
        finish_rsp(4'b0001);
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL basic_rsp_done got=%b exp=0000", rsp_valid); end
        checks++; if (rsp_out !== 16'h0000) begin failures++; $display("FAIL basic_out_zero got=%h exp=0000", rsp_out); end
        checks++; if (rsp_cc !== 4'h0) begin failures++; $display("FAIL basic_cc_zero got=%h exp=0", rsp_cc); end
    endtask

    task automatic test_round_robin();
        int cyc;
        int rr_idx [6];
        logic [3:0]  exp_oh;
        logic [15:0] exp_a;
        rr_idx = '{0, 1, 2, 3, 0, 2};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stub_lat = 0;
        for (int i = 0; i < 4; i++) begin
            req_in1[i] = 16'h1000 + 16'(i);
            req_in2[i] = 16'h2000 + 16'(i);
        end
        req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            exp_oh = 4'(1 << rr_idx[n]);
            exp_a  = 16'h1000 + 16'(rr_idx[n]);
            wait_ready(cyc);
            checks++; if (req_ready !== exp_oh) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", n, req_ready, exp_oh); end
            @(negedge clk);
            checks++; if (div_in1 !== exp_a) begin failures++; $display("FAIL rr_operand%0d got=%h exp=%h", n, div_in1, exp_a); end
            wait_rsp(cyc);
            checks++; if (rsp_valid !== exp_oh) begin failures++; $display("FAIL rr_rsp%0d got=%b exp=%b (waited %0d)", n, rsp_valid, exp_oh, cyc); end
            if (n == 3) req_valid = 4'b0101;
            if (n == 5) req_valid = 4'b0000;
            finish_rsp(exp_oh);
        end
    endtask

    task automatic test_resp_hold();
        int cyc;
        stub_lat = 0; stub_result = 16'h4248; stub_cc = 4'h2; stub_fl = 5'h01;
        req_in1[1] = 16'h4400; req_in2[1] = 16'h3C00; req_valid = 4'b0010;
        wait_ready(cyc);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL hold_grant got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        wait_rsp(cyc);
        req_valid = 4'b1000;
        rsp_ready = 4'b1101;
        for (int n = 0; n < 10; n++) begin
            #1;
            checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL hold_valid%0d got=%b exp=0010", n, rsp_valid); end
            checks++; if (rsp_out !== 16'h4248) begin failures++; $display("FAIL hold_out%0d got=%h exp=4248", n, rsp_out); end
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL hold_ready%0d got=%b exp=0000", n, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL hold_no_grant got=%b exp=0000", req_ready); end
        @(negedge clk);
        rsp_ready = 4'b0000;
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL hold_released got=%b exp=0000", rsp_valid); end
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL hold_next_grant got=%b exp=1000", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic run_to_start(input int idx, input logic [15:0] a, input logic [15:0] b,
                                output logic [3:0] grant);
        int cyc;
        req_in1[idx] = a; req_in2[idx] = b; req_valid = 4'(1 << idx);
        wait_ready(cyc);
        grant = req_ready;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        logic [3:0] g;
        stub_hang = 1'b1; stub_result = 16'h1234; stub_cc = 4'hF; stub_fl = 5'h1F;
        run_to_start(2, 16'h5000, 16'h3C00, g);
        checks++; if (g !== 4'b0100) begin failures++; $display("FAIL to_grant got=%b exp=0100", g); end
        checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", div_start); end
        wait_rsp(cyc);
        checks++; if (cyc !== 17) begin failures++; $display("FAIL to_latency got=%0d exp=17", cyc); end
        checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL to_valid got=%b exp=0100", rsp_valid); end
        checks++; if (rsp_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", rsp_timeout); end
        checks++; if (rsp_out !== 16'h0000) begin failures++; $display("FAIL to_out got=%h exp=0000", rsp_out); end
        checks++; if (rsp_cc !== 4'h0) begin failures++; $display("FAIL to_cc got=%h exp=0", rsp_cc); end
        checks++; if (rsp_flags !== 5'h00) begin failures++; $display("FAIL to_flags got=%h exp=00", rsp_flags); end
        finish_rsp(4'b0100);
        // done arrives on the final timer cycle
        stub_hang = 1'b0; stub_lat = 14; stub_result = 16'h3E00; stub_cc = 4'h3; stub_fl = 5'h04;
        run_to_start(3, 16'h4000, 16'h3C00, g);
        checks++; if (g !== 4'b1000) begin failures++; $display("FAIL edge_grant got=%b exp=1000", g); end
        wait_rsp(cyc);
        checks++; if (cyc !== 17) begin failures++; $display("FAIL edge_latency got=%0d exp=17", cyc); end
        checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL edge_flag got=%b exp=0", rsp_timeout); end
        checks++; if (rsp_out !== 16'h3E00) begin failures++; $display("FAIL edge_out got=%h exp=3e00", rsp_out); end
        finish_rsp(4'b1000);
    endtask

    task automatic test_reset_in_wait();
        int cyc;
        int seen;
        logic [3:0] g;
        stub_hang = 1'b1;
        run_to_start(1, 16'h4500, 16'h4000, g);
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL rw_grant got=%b exp=0010", g); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rw_in_reset_valid got=%b exp=0000", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (div_reset !== 1'b0) begin failures++; $display("FAIL rw_div_reset got=%b exp=0", div_reset); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL rw_div_start got=%b exp=0", div_start); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rw_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL rw_timeout got=%b exp=0", rsp_timeout); end
        checks++; if (div_in1 !== 16'h0000) begin failures++; $display("FAIL rw_div_in1 got=%h exp=0000", div_in1); end
        stub_hang = 1'b0; stub_lat = 0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rw_no_rsp got=%0d cycles with rsp_valid exp=0", seen); end
        req_in1[1] = 16'h3C00; req_in1[3] = 16'h3C00; req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rw_ptr_reset got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        wait_rsp(cyc);
        checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL rw_rsp got=%b exp=0010 (waited %0d)", rsp_valid, cyc); end
        finish_rsp(4'b0010);
    endtask

    task automatic test_div_by_zero();
        int cyc;
        logic [3:0] g;
        stub_lat = 0; stub_result = 16'h7C00; stub_cc = 4'b1010; stub_fl = 5'b00110;
        run_to_start(0, 16'h3C00, 16'h0000, g);
        checks++; if (g !== 4'b0001) begin failures++; $display("FAIL dz_grant got=%b exp=0001", g); end
        checks++; if (div_in2 !== 16'h0000) begin failures++; $display("FAIL dz_in2 got=%h exp=0000", div_in2); end
        wait_rsp(cyc);
        checks++; if (rsp_out !== 16'h7C00) begin failures++; $display("FAIL dz_out got=%h exp=7c00", rsp_out); end
        checks++; if (rsp_cc !== 4'b1010) begin failures++; $display("FAIL dz_cc got=%b exp=1010", rsp_cc); end
        checks++; if (rsp_flags !== 5'b00110) begin failures++; $display("FAIL dz_flags got=%b exp=00110", rsp_flags); end
        checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL dz_timeout got=%b exp=0", rsp_timeout); end
        finish_rsp(4'b0001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        req_in1 = '0;
        req_in2 = '0;
        stub_lat = 0;
        stub_hang = 1'b0;
        stub_result = 16'h0000;
        stub_cc = 4'h0;
        stub_fl = 5'h00;
        test_reset();
        test_basic();
        test_round_robin();
        test_resp_hold();
        test_timeout();
        test_reset_in_wait();
        test_div_by_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
